// File: rtl/btn_debouncer_pkg.sv
// Shared button-path types and lane indices
// for the push-button conditioning block.
package BtnTypes;

  localparam int NUM_BTN = 3;

  typedef logic [NUM_BTN-1:0] BtnPath;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;

endpackage

// File: rtl/btn_debounce_lane.sv
// One button lane: 2-flop synchroniser, debounce
// counter, stable level, edge pulses, sticky flag.
module btn_debounce_lane #(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  input  logic tick,
  input  logic evClear,
  output logic btnLevel,
  output logic btnPress,
  output logic btnRelease,
  output logic btnEvent
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stableNext;
  logic          flip;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;

  // A match resets the run every cycle; ticks only advance it.
  always_comb begin
    stableNext = stable;
    cntNext    = cnt;
    flip       = 1'b0;
    if (sync2 == stable) begin
      cntNext = '0;
    end else if (tick) begin
      if (cnt == LAST) begin
        flip       = 1'b1;
        stableNext = sync2;
        cntNext    = '0;
      end else begin
        cntNext = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      stable     <= 1'b0;
      cnt        <= '0;
      btnPress   <= 1'b0;
      btnRelease <= 1'b0;
      btnEvent   <= 1'b0;
    end else begin
      sync1      <= btnRaw;
      sync2      <= sync1;
      stable     <= stableNext;
      cnt        <= cntNext;
      btnPress   <= flip & sync2;
      btnRelease <= flip & ~sync2;
      btnEvent   <= btnPress | (btnEvent & ~evClear);
    end
  end

  assign btnLevel = stable;

endmodule

// File: rtl/btn_debouncer.sv
// Push-button conditioner: shared sample prescaler
// feeding NUM_BTN independent debounce lanes.
module btn_debouncer #(
  parameter int NUM_BTN      = BtnTypes::NUM_BTN,
  parameter int DEBOUNCE_CNT = 4,
  parameter int SAMPLE_DIV   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btnRaw,
  input  logic [NUM_BTN-1:0] evClear,
  output logic [NUM_BTN-1:0] btnLevel,
  output logic [NUM_BTN-1:0] btnPress,
  output logic [NUM_BTN-1:0] btnRelease,
  output logic [NUM_BTN-1:0] btnEvent
);

  import BtnTypes::*;

  localparam int PW =
    (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(SAMPLE_DIV - 1);

  if (DEBOUNCE_CNT < 1) begin : gBadCnt
    $error("btn_debouncer: DEBOUNCE_CNT must be >= 1");
  end
  if (SAMPLE_DIV < 1) begin : gBadDiv
    $error("btn_debouncer: SAMPLE_DIV must be >= 1");
  end

  logic [PW-1:0] preCnt;
  logic          tick;

  assign tick = (preCnt == PLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preCnt <= '0;
    end else if (tick) begin
      preCnt <= '0;
    end else begin
      preCnt <= preCnt + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : gLane
    btn_debounce_lane #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) uLane (
      .clk       (clk),
      .rst       (rst),
      .btnRaw    (btnRaw[i]),
      .tick      (tick),
      .evClear   (evClear[i]),
      .btnLevel  (btnLevel[i]),
      .btnPress  (btnPress[i]),
      .btnRelease(btnRelease[i]),
      .btnEvent  (btnEvent[i])
    );
  end

endmodule
